// File: rtl/rvfi_insn_stream_check.sv
// RVFI retire-stream checker.
// Captures retired instructions into a small FIFO, checks the retire order
// as records arrive, and replays each queued record to an external
// reference model. The reference result is compared against the retired
// post-state. Error flags are sticky. check_count counts completed comparisons.
//
// Handshake contract (spec_req_*): spec_req_valid is high exactly while the
// dispatcher is in REQ. The head operands stay stable until a cycle where
// spec_req_valid and spec_req_ready are both 1. spec_req_ready has no meaning
// while spec_req_valid is 0. spec_rsp_valid is a one-cycle strobe, and it is
// honoured only while waiting for a result.
module rvfi_insn_stream_check #(
  parameter int NRET    = 1,
  parameter int XLEN    = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NRET-1:0]           rvfi_valid,
  input  logic [NRET*64-1:0]        rvfi_order,
  input  logic [NRET*32-1:0]        rvfi_insn,
  input  logic [NRET*XLEN-1:0]      rvfi_pre_pc,
  input  logic [NRET*XLEN-1:0]      rvfi_pre_rs1,
  input  logic [NRET*XLEN-1:0]      rvfi_pre_rs2,
  input  logic [NRET*5-1:0]         rvfi_rd,
  input  logic [NRET*XLEN-1:0]      rvfi_post_rd,
  input  logic [NRET*XLEN-1:0]      rvfi_post_pc,
  input  logic [NRET-1:0]           rvfi_post_trap,
  output logic                      spec_req_valid,
  input  logic                      spec_req_ready,
  output logic [31:0]               spec_req_insn,
  output logic [XLEN-1:0]           spec_req_pc,
  output logic [XLEN-1:0]           spec_req_rs1,
  output logic [XLEN-1:0]           spec_req_rs2,
  input  logic                      spec_rsp_valid,
  input  logic [4:0]                spec_rsp_rd,
  input  logic [XLEN-1:0]           spec_rsp_post_rd,
  input  logic [XLEN-1:0]           spec_rsp_post_pc,
  input  logic                      spec_rsp_trap,
  output logic [4:0]                err_flags,
  output logic [31:0]               check_count,
  output logic [1:0]                dbg_state,
  output logic [$clog2(DEPTH):0]    dbg_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_CMP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // FIFO storage, one array per record field
  logic [31:0]     mem_insn    [DEPTH];
  logic [XLEN-1:0] mem_pc      [DEPTH];
  logic [XLEN-1:0] mem_rs1     [DEPTH];
  logic [XLEN-1:0] mem_rs2     [DEPTH];
  logic [4:0]      mem_rd      [DEPTH];
  logic [XLEN-1:0] mem_post_rd [DEPTH];
  logic [XLEN-1:0] mem_post_pc [DEPTH];
  logic            mem_trap    [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr, slot_off;
  logic [AW-1:0] wr_slot [NRET];
  logic [CW-1:0] count, n_valid, free_cnt, push_n;
  logic          push, overflow, pop;

  logic [63:0]   exp_order, run_exp;
  logic          order_set, run_set, ord_err;

  logic [TW-1:0] wait_cnt;
  logic          wait_done, tmo_evt, cmp_now;

  logic [4:0]      rsp_rd_q;
  logic [XLEN-1:0] rsp_post_rd_q, rsp_post_pc_q;
  logic            rsp_trap_q;
  logic            data_err, trap_err;

  // Count the valid channels and decide whether the whole group fits.
  // Only the current occupancy counts as used space; a pop in the same
  // cycle does not make room.
  always_comb begin
    n_valid = '0;
    for (int i = 0; i < NRET; i++) begin
      n_valid = n_valid + {{(CW-1){1'b0}}, rvfi_valid[i]};
    end
    free_cnt = CW'(DEPTH) - count;
    push     = enable && (n_valid != '0) && (n_valid <= free_cnt);
    overflow = enable && (n_valid > free_cnt);
    push_n   = push ? n_valid : '0;
  end

  // Valid channels take consecutive slots in ascending channel order.
  always_comb begin
    slot_off = '0;
    for (int i = 0; i < NRET; i++) begin
      wr_slot[i] = wr_ptr + slot_off;
      slot_off   = slot_off + {{(AW-1){1'b0}}, rvfi_valid[i]};
    end
  end

  // Walk the accepted records in channel order and check retire continuity.
  always_comb begin
    ord_err = 1'b0;
    run_exp = exp_order;
    run_set = order_set;
    for (int i = 0; i < NRET; i++) begin
      if (push && rvfi_valid[i]) begin
        if (run_set && (rvfi_order[i*64 +: 64] != run_exp)) ord_err = 1'b1;
        run_exp = rvfi_order[i*64 +: 64] + 64'd1;
        run_set = 1'b1;
      end
    end
  end

  // Write accepted records into the FIFO storage.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NRET; i++) begin
      if (push && rvfi_valid[i]) begin
        mem_insn[wr_slot[i]]    <= rvfi_insn[i*32 +: 32];
        mem_pc[wr_slot[i]]      <= rvfi_pre_pc[i*XLEN +: XLEN];
        mem_rs1[wr_slot[i]]     <= rvfi_pre_rs1[i*XLEN +: XLEN];
        mem_rs2[wr_slot[i]]     <= rvfi_pre_rs2[i*XLEN +: XLEN];
        mem_rd[wr_slot[i]]      <= rvfi_rd[i*5 +: 5];
        mem_post_rd[wr_slot[i]] <= rvfi_post_rd[i*XLEN +: XLEN];
        mem_post_pc[wr_slot[i]] <= rvfi_post_pc[i*XLEN +: XLEN];
        mem_trap[wr_slot[i]]    <= rvfi_post_trap[i];
      end
    end
  end

  // FIFO pointers, occupancy and the expected-order tracker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      exp_order <= '0;
      order_set <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + n_valid[AW-1:0];
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + push_n - {{(CW-1){1'b0}}, pop};
      if (push) begin
        exp_order <= run_exp;
        order_set <= run_set;
      end
    end
  end

  assign wait_done = (wait_cnt == TW'(TIMEOUT - 1));
  assign tmo_evt   = (state == S_WAIT) && !spec_rsp_valid && wait_done;
  assign cmp_now   = (state == S_CMP);
  assign pop       = cmp_now || tmo_evt;

  // Dispatcher state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Dispatcher next-state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (count != '0) state_nxt = S_REQ;
      S_REQ:  if (spec_req_ready) state_nxt = S_WAIT;
      S_WAIT: begin
        if (spec_rsp_valid) state_nxt = S_CMP;
        else if (wait_done) state_nxt = S_IDLE;
      end
      S_CMP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Response wait counter; it restarts from zero on every entry to WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 wait_cnt <= '0;
    else if (state != S_WAIT)  wait_cnt <= '0;
    else                       wait_cnt <= wait_cnt + TW'(1);
  end

  // Latch the reference result when it arrives during WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rd_q      <= '0;
      rsp_post_rd_q <= '0;
      rsp_post_pc_q <= '0;
      rsp_trap_q    <= 1'b0;
    end else if ((state == S_WAIT) && spec_rsp_valid) begin
      rsp_rd_q      <= spec_rsp_rd;
      rsp_post_rd_q <= spec_rsp_post_rd;
      rsp_post_pc_q <= spec_rsp_post_pc;
      rsp_trap_q    <= spec_rsp_trap;
    end
  end

  // Compare the latched result with the head record. Data is only
  // meaningful when neither side trapped. A write to x0 that claims a
  // nonzero value is always wrong.
  always_comb begin
    data_err = 1'b0;
    trap_err = 1'b0;
    if (rsp_trap_q != mem_trap[rd_ptr]) begin
      trap_err = 1'b1;
    end else if (!mem_trap[rd_ptr]) begin
      if ((rsp_rd_q != mem_rd[rd_ptr]) ||
          (rsp_post_rd_q != mem_post_rd[rd_ptr]) ||
          (rsp_post_pc_q != mem_post_pc[rd_ptr])) data_err = 1'b1;
      if ((mem_rd[rd_ptr] == 5'd0) && (mem_post_rd[rd_ptr] != '0)) data_err = 1'b1;
    end
  end

  // Sticky error flags and the saturating comparison counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_flags   <= '0;
      check_count <= '0;
    end else begin
      err_flags <= err_flags | {tmo_evt, overflow, ord_err,
                                cmp_now && trap_err, cmp_now && data_err};
      if (cmp_now && (check_count != 32'hFFFF_FFFF)) check_count <= check_count + 32'd1;
    end
  end

  assign spec_req_valid = (state == S_REQ);
  assign spec_req_insn  = mem_insn[rd_ptr];
  assign spec_req_pc    = mem_pc[rd_ptr];
  assign spec_req_rs1   = mem_rs1[rd_ptr];
  assign spec_req_rs2   = mem_rs2[rd_ptr];
  assign dbg_state      = state;
  assign dbg_count      = count;

endmodule

// File: tb/tb_rvfi_insn_stream_check.sv
// Testbench for rvfi_insn_stream_check: a reactive reference-model responder
// plus a record-level model of order, overflow, compare and timeout rules.
module tb_rvfi_insn_stream_check;

  localparam int NRET = 2;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 15;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn, pc, rs1, rs2;
    logic [4:0]  rd;
    logic [31:0] post_rd, post_pc;
    logic        trap;
  } rec_t;

  logic clk, reset, enable;
  logic [NRET-1:0]      rvfi_valid, rvfi_post_trap;
  logic [NRET*64-1:0]   rvfi_order;
  logic [NRET*32-1:0]   rvfi_insn;
  logic [NRET*XLEN-1:0] rvfi_pre_pc, rvfi_pre_rs1, rvfi_pre_rs2, rvfi_post_rd, rvfi_post_pc;
  logic [NRET*5-1:0]    rvfi_rd;
  logic spec_req_valid, spec_req_ready, spec_rsp_valid, spec_rsp_trap;
  logic [31:0] spec_req_insn, spec_req_pc, spec_req_rs1, spec_req_rs2;
  logic [4:0]  spec_rsp_rd;
  logic [31:0] spec_rsp_post_rd, spec_rsp_post_pc;
  logic [4:0]  err_flags;
  logic [31:0] check_count;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_count;

  rvfi_insn_stream_check #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_pre_pc(rvfi_pre_pc), .rvfi_pre_rs1(rvfi_pre_rs1), .rvfi_pre_rs2(rvfi_pre_rs2),
    .rvfi_rd(rvfi_rd), .rvfi_post_rd(rvfi_post_rd), .rvfi_post_pc(rvfi_post_pc),
    .rvfi_post_trap(rvfi_post_trap),
    .spec_req_valid(spec_req_valid), .spec_req_ready(spec_req_ready),
    .spec_req_insn(spec_req_insn), .spec_req_pc(spec_req_pc),
    .spec_req_rs1(spec_req_rs1), .spec_req_rs2(spec_req_rs2),
    .spec_rsp_valid(spec_rsp_valid), .spec_rsp_rd(spec_rsp_rd),
    .spec_rsp_post_rd(spec_rsp_post_rd), .spec_rsp_post_pc(spec_rsp_post_pc),
    .spec_rsp_trap(spec_rsp_trap),
    .err_flags(err_flags), .check_count(check_count),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard and model state
  int n_checks = 0;
  int n_fail = 0;
  logic [127:0] exp_q[$];
  rec_t rec_q[$];
  int occ;
  logic [63:0] exp_order;
  bit order_set;
  logic [4:0] exp_err;
  logic [31:0] exp_count;
  int rsp_mode;    // 0 echo, 1 corrupt post_rd, 2 flip trap, 3 silent, 4 abandon
  int ready_mode;  // 0 always ready, 1 random, 2 never
  rec_t ch[NRET];

  function automatic void model_clear();
    exp_q.delete();
    rec_q.delete();
    occ = 0;
    exp_order = '0;
    order_set = 1'b0;
    exp_err = '0;
    exp_count = '0;
  endfunction

  function automatic rec_t rand_rec(input logic [63:0] order);
    rec_t r;
    r.order = order;
    r.insn = $urandom; r.pc = $urandom; r.rs1 = $urandom; r.rs2 = $urandom;
    r.rd = 5'($urandom_range(1, 31));
    r.post_rd = $urandom; r.post_pc = $urandom;
    r.trap = 1'b0;
    return r;
  endfunction

  // Expected error bits for one reference answer against its retired record
  function automatic logic [4:0] cmp_err(input rec_t r, input logic [4:0] rd,
                                         input logic [31:0] prd, input logic [31:0] ppc,
                                         input logic tr);
    logic [4:0] e;
    e = '0;
    if (tr !== r.trap) e[1] = 1'b1;
    else if (!tr) begin
      if (rd !== r.rd || prd !== r.post_rd || ppc !== r.post_pc) e[0] = 1'b1;
      if (r.rd == 5'd0 && r.post_rd != 32'd0) e[0] = 1'b1;
    end
    return e;
  endfunction

  // Driver: present one retire cycle built from ch[] and update the model
  task automatic retire_cycle(input logic [NRET-1:0] mask, input logic en);
    int n;
    n = 0;
    @(negedge clk);
    enable = en;
    rvfi_valid = mask;
    for (int i = 0; i < NRET; i++) begin
      rvfi_order[i*64 +: 64]     = ch[i].order;
      rvfi_insn[i*32 +: 32]      = ch[i].insn;
      rvfi_pre_pc[i*XLEN +: XLEN]  = ch[i].pc;
      rvfi_pre_rs1[i*XLEN +: XLEN] = ch[i].rs1;
      rvfi_pre_rs2[i*XLEN +: XLEN] = ch[i].rs2;
      rvfi_rd[i*5 +: 5]          = ch[i].rd;
      rvfi_post_rd[i*XLEN +: XLEN] = ch[i].post_rd;
      rvfi_post_pc[i*XLEN +: XLEN] = ch[i].post_pc;
      rvfi_post_trap[i]          = ch[i].trap;
      n += int'(mask[i]);
    end
    if (en && n > 0) begin
      if (occ + n > DEPTH) exp_err[3] = 1'b1;
      else begin
        for (int i = 0; i < NRET; i++) begin
          if (mask[i]) begin
            if (order_set && ch[i].order != exp_order) exp_err[2] = 1'b1;
            exp_order = ch[i].order + 64'd1;
            order_set = 1'b1;
            exp_q.push_back({ch[i].insn, ch[i].pc, ch[i].rs1, ch[i].rs2});
            rec_q.push_back(ch[i]);
            occ++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    rvfi_valid = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rvfi_valid = '0;
    repeat (2) @(negedge clk);
    model_clear();
    reset = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (occ > 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (occ != 0) begin
      n_fail++;
      $display("FAIL drain: %0d records still outstanding, required 0", occ);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_state(input string name);
    n_checks++;
    if (err_flags !== exp_err) begin
      n_fail++;
      $display("FAIL %s err_flags: got %b expected %b", name, err_flags, exp_err);
    end
    n_checks++;
    if (check_count !== exp_count) begin
      n_fail++;
      $display("FAIL %s check_count: got %0d expected %0d", name, check_count, exp_count);
    end
  endtask

  // Reference-model responder: serves one accepted request
  task automatic serve(input rec_t r, input int mode);
    logic [4:0] rd;
    logic [31:0] prd, ppc;
    logic tr;
    int d;
    if (mode == 4) return;
    if (mode == 3) begin
      repeat (TIMEOUT) @(negedge clk);
      n_checks++;
      if (dbg_state !== ST_WAIT || err_flags[4] !== exp_err[4]) begin
        n_fail++;
        $display("FAIL tmo_early: state %0d tmo %b, required state %0d tmo %b",
                 dbg_state, err_flags[4], ST_WAIT, exp_err[4]);
      end
      @(negedge clk);
      exp_err[4] = 1'b1;
      n_checks++;
      if (err_flags[4] !== 1'b1 || dbg_state !== ST_IDLE) begin
        n_fail++;
        $display("FAIL tmo_fire: state %0d tmo %b, required state %0d tmo 1",
                 dbg_state, err_flags[4], ST_IDLE);
      end
      occ--;
      return;
    end
    @(negedge clk);
    d = $urandom_range(0, 3);
    repeat (d) @(negedge clk);
    rd = r.rd; prd = r.post_rd; ppc = r.post_pc; tr = r.trap;
    if (mode == 1) prd[0] = ~prd[0];
    if (mode == 2) tr = ~tr;
    spec_rsp_valid = 1'b1;
    spec_rsp_rd = rd; spec_rsp_post_rd = prd; spec_rsp_post_pc = ppc; spec_rsp_trap = tr;
    exp_err = exp_err | cmp_err(r, rd, prd, ppc, tr);
    if (exp_count != 32'hFFFF_FFFF) exp_count++;
    @(negedge clk);
    spec_rsp_valid = 1'b0;
    @(negedge clk);
    occ--;
  endtask

  initial begin
    logic [127:0] req;
    rec_t r;
    spec_req_ready = 1'b0;
    spec_rsp_valid = 1'b0;
    spec_rsp_rd = '0; spec_rsp_post_rd = '0; spec_rsp_post_pc = '0; spec_rsp_trap = 1'b0;
    forever begin
      @(negedge clk);
      spec_rsp_valid = 1'b0;
      if (reset) begin
        spec_req_ready = 1'b0;
        continue;
      end
      case (ready_mode)
        0: spec_req_ready = 1'b1;
        1: spec_req_ready = 1'($urandom_range(0, 1));
        default: spec_req_ready = 1'b0;
      endcase
      if (spec_req_valid && spec_req_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL req_unexpected: request %h with empty model queue",
                   {spec_req_insn, spec_req_pc, spec_req_rs1, spec_req_rs2});
        end else begin
          req = exp_q.pop_front();
          r = rec_q.pop_front();
          if ({spec_req_insn, spec_req_pc, spec_req_rs1, spec_req_rs2} !== req) begin
            n_fail++;
            $display("FAIL req_fields: got %h expected %h",
                     {spec_req_insn, spec_req_pc, spec_req_rs1, spec_req_rs2}, req);
          end
          serve(r, rsp_mode);
        end
      end else if (rsp_mode < 3 && $urandom_range(0, 7) == 0) begin
        // stray strobe while not waiting; the checker must ignore it
        spec_rsp_valid = 1'b1;
      end
    end
  end

  // Tests
  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; rvfi_valid = '0;
    rvfi_order = '0; rvfi_insn = '0; rvfi_pre_pc = '0; rvfi_pre_rs1 = '0; rvfi_pre_rs2 = '0;
    rvfi_rd = '0; rvfi_post_rd = '0; rvfi_post_pc = '0; rvfi_post_trap = '0;
    rsp_mode = 0; ready_mode = 0;
    model_clear();
    repeat (3) @(negedge clk);
    check_state("reset");
    n_checks++;
    if (spec_req_valid !== 1'b0 || dbg_count !== 3'd0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_ctl: valid %b count %0d state %0d, required 0 0 0",
               spec_req_valid, dbg_count, dbg_state);
    end
    reset = 1'b0;
  endtask

  task automatic test_dual_retire();
    do_reset();
    rsp_mode = 0; ready_mode = 0;
    ch[0] = rand_rec(64'd0);
    ch[1] = rand_rec(64'd1);
    retire_cycle(2'b11, 1'b1);
    n_checks++;
    if (dbg_count !== 3'd2) begin
      n_fail++;
      $display("FAIL dual_capture: fifo count %0d, required 2", dbg_count);
    end
    drain();
    check_state("dual_retire");
    n_checks++;
    if (check_count !== 32'd2 || err_flags !== 5'b00000) begin
      n_fail++;
      $display("FAIL dual_const: count %0d err %b, required 2 00000", check_count, err_flags);
    end
  endtask

  task automatic test_order();
    do_reset();
    rsp_mode = 0; ready_mode = 0;
    ch[0] = rand_rec(64'd5); retire_cycle(2'b01, 1'b1);
    ch[0] = rand_rec(64'd7); retire_cycle(2'b01, 1'b1);
    drain();
    n_checks++;
    if (err_flags !== 5'b00100) begin
      n_fail++;
      $display("FAIL order_gap: err %b, required 00100", err_flags);
    end
    ch[0] = rand_rec(64'd8); retire_cycle(2'b01, 1'b1);
    drain();
    check_state("order_resync");
    do_reset();
    ch[0] = rand_rec(64'hFFFF_FFFF_FFFF_FFFF);
    ch[1] = rand_rec(64'd0);
    retire_cycle(2'b11, 1'b1);
    drain();
    check_state("order_wrap");
  endtask

  task automatic test_compare();
    do_reset();
    ready_mode = 0;
    rsp_mode = 1;
    ch[0] = rand_rec(64'd0); ch[0].rd = 5'd3; ch[0].post_rd = 32'h11;
    retire_cycle(2'b01, 1'b1);
    drain();
    n_checks++;
    if (err_flags !== 5'b00001) begin
      n_fail++;
      $display("FAIL data_mismatch: err %b, required 00001", err_flags);
    end
    rsp_mode = 2;
    ch[0] = rand_rec(64'd1);
    retire_cycle(2'b01, 1'b1);
    drain();
    n_checks++;
    if (err_flags !== 5'b00011) begin
      n_fail++;
      $display("FAIL trap_mismatch: err %b, required 00011", err_flags);
    end
    check_state("compare");
    do_reset();
    rsp_mode = 0;
    ch[0] = rand_rec(64'd0); ch[0].rd = 5'd0; ch[0].post_rd = 32'd5;
    retire_cycle(2'b01, 1'b1);
    drain();
    check_state("x0_write");
    do_reset();
    rsp_mode = 1;
    ch[0] = rand_rec(64'd0); ch[0].trap = 1'b1;
    retire_cycle(2'b01, 1'b1);
    drain();
    check_state("both_trap");
  endtask

  task automatic test_timeout();
    do_reset();
    ready_mode = 0; rsp_mode = 3;
    ch[0] = rand_rec(64'd0);
    retire_cycle(2'b01, 1'b1);
    drain();
    check_state("timeout");
    n_checks++;
    if (err_flags !== 5'b10000 || check_count !== 32'd0 || dbg_count !== 3'd0) begin
      n_fail++;
      $display("FAIL timeout_const: err %b count %0d fifo %0d, required 10000 0 0",
               err_flags, check_count, dbg_count);
    end
    rsp_mode = 0;
    ch[0] = rand_rec(64'd1);
    retire_cycle(2'b01, 1'b1);
    drain();
    check_state("after_timeout");
  endtask

  task automatic test_overflow();
    rec_t first;
    do_reset();
    ready_mode = 2; rsp_mode = 0;
    for (int k = 0; k < 5; k++) begin
      ch[0] = rand_rec(64'(k));
      if (k == 0) first = ch[0];
      retire_cycle(2'b01, 1'b1);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (err_flags !== 5'b01000 || dbg_count !== 3'd4) begin
      n_fail++;
      $display("FAIL overflow: err %b fifo %0d, required 01000 4", err_flags, dbg_count);
    end
    n_checks++;
    if (spec_req_valid !== 1'b1 || spec_req_insn !== first.insn) begin
      n_fail++;
      $display("FAIL stall_head: valid %b insn %h, required 1 %h",
               spec_req_valid, spec_req_insn, first.insn);
    end
    ready_mode = 0;
    drain();
    check_state("overflow_drain");
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready_mode = 0; rsp_mode = 0;
    ch[0] = rand_rec(64'd10); ch[1] = rand_rec(64'd11); retire_cycle(2'b11, 1'b1);
    ch[0] = rand_rec(64'd12); ch[1] = rand_rec(64'd13); retire_cycle(2'b11, 1'b1);
    ch[0] = rand_rec(64'd14); retire_cycle(2'b01, 1'b1);
    drain();
    check_state("back_to_back");
  endtask

  task automatic test_enable_off();
    do_reset();
    ready_mode = 1; rsp_mode = 0;
    ch[0] = rand_rec(64'd0); ch[1] = rand_rec(64'd1); retire_cycle(2'b11, 1'b1);
    ch[0] = rand_rec(64'd2); retire_cycle(2'b01, 1'b1);
    for (int k = 0; k < 10; k++) begin
      ch[0] = rand_rec(64'($urandom)); ch[1] = rand_rec(64'($urandom));
      retire_cycle(2'($urandom_range(0, 3)), 1'b0);
    end
    drain();
    check_state("enable_off");
    n_checks++;
    if (dbg_count !== 3'd0) begin
      n_fail++;
      $display("FAIL enable_off_fifo: fifo %0d, required 0", dbg_count);
    end
  endtask

  task automatic test_random();
    logic [63:0] base;
    logic [1:0] mask;
    do_reset();
    ready_mode = 1;
    for (int it = 0; it < 40; it++) begin
      rsp_mode = $urandom_range(0, 2);
      base = order_set ? exp_order : {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 7) == 0) base = base + 64'($urandom_range(1, 3));
      for (int i = 0; i < NRET; i++) begin
        ch[i] = rand_rec(base + 64'(i));
        ch[i].rd = 5'($urandom_range(0, 31));
        if (ch[i].rd == 5'd0 && $urandom_range(0, 1) == 0) ch[i].post_rd = '0;
        ch[i].trap = ($urandom_range(0, 5) == 0);
      end
      mask = 2'($urandom_range(0, 3));
      retire_cycle(mask, ($urandom_range(0, 4) != 0));
      drain();
      check_state("random");
    end
  endtask

  task automatic test_reset_mid_wait();
    int t;
    ready_mode = 0; rsp_mode = 4;
    ch[0] = rand_rec(exp_order); ch[1] = rand_rec(exp_order + 64'd1);
    retire_cycle(2'b11, 1'b1);
    ch[0] = rand_rec(exp_order);
    retire_cycle(2'b01, 1'b1);
    t = 0;
    while (dbg_state !== ST_WAIT && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL async_reset: state %0d, required %0d", dbg_state, ST_IDLE);
    end
    @(negedge clk);
    n_checks++;
    if (spec_req_valid !== 1'b0 || check_count !== 32'd0 || err_flags !== 5'd0 || dbg_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: valid %b count %0d err %b fifo %0d, required 0 0 00000 0",
               spec_req_valid, check_count, err_flags, dbg_count);
    end
    model_clear();
    reset = 1'b0;
    rsp_mode = 0;
    ch[0] = rand_rec(64'd100);
    retire_cycle(2'b01, 1'b1);
    drain();
    check_state("after_reset");
  endtask

  initial begin
    test_reset();
    test_dual_retire();
    test_order();
    test_compare();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_enable_off();
    test_random();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvfi_insn_stream_check.md
RVFI_INSN_STREAM_CHECK -- requirements
Module: rvfi_insn_stream_check

Interface
REQ-001 SHALL have parameter NRET, default 1, retire channels per cycle (1..4).
REQ-002 SHALL have parameter XLEN, default 32, register width (32 or 64).
REQ-003 SHALL have parameter DEPTH, default 8, retire FIFO entries (power of 2, 4..16, DEPTH >= NRET).
REQ-004 SHALL have parameter TIMEOUT, default 15, maximum spec-response wait cycles.
REQ-005 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port: enable  in  1  capture enable.
REQ-008 SHALL have port: rvfi_valid  in  NRET  per-channel retire strobe.
REQ-009 SHALL have port: rvfi_order  in  NRET*64  retire index.
REQ-010 SHALL have port: rvfi_insn  in  NRET*32  instruction word.
REQ-011 SHALL have port: rvfi_pre_pc, rvfi_pre_rs1, rvfi_pre_rs2  in  NRET*XLEN each  pre-state (three ports).
REQ-012 SHALL have port: rvfi_rd  in  NRET*5  destination register.
REQ-013 SHALL have port: rvfi_post_rd, rvfi_post_pc  in  NRET*XLEN each  post-state (two ports).
REQ-014 SHALL have port: rvfi_post_trap  in  NRET  trap flag.
REQ-015 SHALL have port: spec_req_valid  out  1  request to reference model.
REQ-016 SHALL have port: spec_req_ready  in  1  reference model accepts request.
REQ-017 SHALL have port: spec_req_insn/pc/rs1/rs2  out  32/XLEN/XLEN/XLEN  head-entry operands (four ports).
REQ-018 SHALL have port: spec_rsp_valid  in  1  single-cycle reference result strobe.
REQ-019 SHALL have port: spec_rsp_rd/post_rd/post_pc/trap  in  5/XLEN/XLEN/1  reference result (four ports).
REQ-020 SHALL have port: err_flags  out  5  sticky {TMO,OVF,ORD,TRAP,DATA} (bit4..0).
REQ-021 SHALL have port: check_count  out  32  completed comparisons, saturating.

Function
REQ-022 Capture SHALL occur only when enable=1; valid channels are pushed in ascending channel index, all in the same cycle.
REQ-023 If free entries < number of valid channels, the block SHALL drop all records of that cycle and set OVF; a simultaneous pop SHALL NOT count as freed space.
REQ-024 First captured record SHALL initialise expected order; each later record SHALL match expected (else set ORD, resynchronise to record order); expected increments by 1 per record, 64-bit wrap.
REQ-025 Dispatch FSM states: IDLE, REQ, WAIT, CMP; IDLE->REQ when FIFO non-empty (registered, 1-cycle min).
REQ-026 REQ: spec_req_valid=1 with head fields stable until spec_req_ready=1 sampled, then ->WAIT; ready ignored when valid=0.
REQ-027 WAIT: cycle counter from 0; spec_rsp_valid=1 latches result ->CMP; counter reaching TIMEOUT without response sets TMO, pops head, ->IDLE; responses outside WAIT SHALL be ignored.
REQ-028 CMP (one cycle): rsp_trap != post_trap sets TRAP; if both trap=0, any mismatch of rd, post_rd, post_pc sets DATA, and rd=0 with post_rd!=0 sets DATA; pops head, check_count+1 (saturates at 0xFFFFFFFF), ->IDLE.
REQ-029 err_flags bits SHALL be set-only, registered, visible the cycle after the causing event.
REQ-030 enable=0 SHALL stop capture only; queued entries keep draining.

Reset
REQ-031 Reset assertion SHALL immediately force FSM=IDLE, FIFO empty, expected-order unset, spec_req_valid=0, err_flags=0, check_count=0, also mid-transaction; the in-flight request is abandoned.

Verification
REQ-032 NRET=2, orders 0,1 same cycle, spec echoes correct values -> two CMP passes, check_count=2, err_flags=0.
REQ-033 Retire order 5 then 7 -> err_flags=5'b00100; next record 8 accepted without new error.
REQ-034 DEPTH=4, spec_req_ready held 0, push 5 single records -> 5th dropped, err_flags[3]=1, FIFO holds 4.
REQ-035 Response post_rd=0x10 vs retired 0x11, both trap=0 -> err_flags=5'b00001; trap mismatch -> bit1.
REQ-036 No spec_rsp_valid for 15 WAIT cycles -> err_flags[4]=1, head popped, check_count unchanged.
REQ-037 reset pulsed in WAIT with 3 entries queued -> next cycle spec_req_valid=0, check_count=0, err_flags=0, FIFO empty.
